pc_redirect_ctrl: RTL

Owns the program counter and sequences the 3-way PC-select mux (00 normal, 01 jump target, 10 jump register) in the 5-stage MIPS pipeline. Arbitrates between sequential/branch fetch, J/JAL resolved in ID and JR resolved in EX, using fixed older-instruction-wins priority. Holds redirects that arrive during a pipeline stall and replays them when the stall releases, generating the matching IF/ID and ID/EX flushes.

---
 rtl/mips_pc_pkg.sv | 16 +
 rtl/pc_redirect_hold.sv | 40 ++++
 rtl/pc_redirect_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the MIPS PC-select path.
package mips_pc_pkg;

  typedef enum logic [1:0] {
    SEL_NORMAL = 2'b00,
    SEL_JUMP   = 2'b01,
    SEL_JR     = 2'b10
  } pc_sel_t;

  typedef logic [0:0] ctrl_state_t;
  localparam ctrl_state_t RUN  = 1'b0;
  localparam ctrl_state_t PEND = 1'b1;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_redirect_hold.sv
// Holds the redirect kind/target captured during a stall; a later JR
// replaces a held J/JAL or an older JR, a later J/JAL never replaces anything.
module pc_redirect_hold
  import mips_pc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic        update,
  input  logic        clear,
  input  logic        jr_req,
  input  logic [31:0] jr_target,
  input  logic [31:0] jump_target,
  output pc_sel_t     held_sel,
  output logic [31:0] held_target
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_sel    <= SEL_NORMAL;
      held_target <= 32'h0;
    end else if (clear) begin
      held_sel    <= SEL_NORMAL;
      held_target <= 32'h0;
    end else if (capture) begin
      // capture is only raised with a request present, so !jr_req means jump
      if (jr_req) begin
        held_sel    <= SEL_JR;
        held_target <= jr_target;
      end else begin
        held_sel    <= SEL_JUMP;
        held_target <= jump_target;
      end
    end else if (update && jr_req) begin
      held_sel    <= SEL_JR;
      held_target <= jr_target;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC owner and next-PC select/flush sequencer; older instruction wins (JR > J > seq).
// Define PC_ALIGN_CHECK_EN to trap misaligned redirect targets to EXC_VECTOR.
//
// state | meaning
// RUN   | normal fetch; redirects applied immediately when not stalled
// PEND  | redirect captured during a stall, replayed when stall drops
module pc_redirect_ctrl
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PC_ALIGN_CHECK_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jumpReq,
  input  logic [31:0] jumpTarget,
  input  logic        jrReq,
  input  logic [31:0] jrTarget,
  output logic [31:0] pc,
  output logic [1:0]  pcSel,
  output logic [31:0] nextPc,
  output logic        flushIfId,
  output logic        flushIdEx,
`ifdef PC_ALIGN_CHECK_EN
  output logic        alignErr,
`endif
  output logic        pending
);

  ctrl_state_t state, state_nxt;
  pc_sel_t     sel, held_sel;
  logic [31:0] tgt, held_target, normal_addr;
  logic        redirect;
  logic        capture, update, clear;

  assign capture = (state == RUN) && stall && (jrReq || jumpReq);
  assign update  = (state == PEND) && stall;
  assign clear   = (state == PEND) && !stall;
  assign pending = (state == PEND);

  pc_redirect_hold u_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture     (capture),
    .update      (update),
    .clear       (clear),
    .jr_req      (jrReq),
    .jr_target   (jrTarget),
    .jump_target (jumpTarget),
    .held_sel    (held_sel),
    .held_target (held_target)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned;
`endif

  always_comb begin
    normal_addr = branchTaken ? branchTarget : pc + PC_STEP;
    state_nxt   = state;
    redirect    = 1'b0;
    sel         = SEL_NORMAL;
    tgt         = pc;
    case (state)
      RUN: begin
        if (!stall) begin
          if (jrReq) begin
            redirect = 1'b1;
            sel      = SEL_JR;
            tgt      = jrTarget;
          end else if (jumpReq) begin
            redirect = 1'b1;
            sel      = SEL_JUMP;
            tgt      = jumpTarget;
          end else begin
            tgt = normal_addr;
          end
        end else if (jrReq || jumpReq) begin
          state_nxt = PEND;
        end
      end
      PEND: begin
        // live requests during replay are on the wrong path and are dropped
        if (!stall) begin
          redirect  = 1'b1;
          sel       = held_sel;
          tgt       = held_target;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase

    pcSel     = sel;
    nextPc    = tgt;
    flushIfId = redirect;
    flushIdEx = redirect && (sel == SEL_JR);
`ifdef PC_ALIGN_CHECK_EN
    misaligned = redirect && (tgt[1:0] != 2'b00);
    if (misaligned) begin
      pcSel     = SEL_NORMAL;
      nextPc    = EXC_VECTOR;
      flushIdEx = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= nextPc;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alignErr <= 1'b0;
    else        alignErr <= misaligned;
  end
`endif

endmodule
